// File: rtl/devil_pattern_matcher.sv
// -----------------------------------------------------------------------------
// devil_pattern_matcher
//
// Passively taps one data channel of a coherent interconnect and raises a
// one-cycle pulse whenever a complete, correctly aligned cache line equals a
// target pattern. It also flags bursts whose length differs from one line and
// keeps a saturating count of matches.
//
// Ports
//   ace_aclk        clock; all logic runs on its rising edge
//   ace_aresetn     asynchronous, active-low reset
//   i_enable        arms matching (held high while the controller is leaking)
//   i_pattern       target line; slice k (C_ACE_DATA_WIDTH bits) is beat k
//   i_data_valid    tapped channel valid
//   i_data_ready    tapped channel ready (observed only)
//   i_data          tapped beat payload
//   i_data_last     tapped channel last-beat marker
//   i_clear         synchronous clear of o_match_count
//   o_pattern_match one-cycle pulse, one cycle after the last beat of a match
//   o_protocol_err  one-cycle pulse when a burst is not exactly one line long
//   o_match_count   saturating match counter
//   o_busy          high while collecting or flushing a burst
// -----------------------------------------------------------------------------
module devil_pattern_matcher #(
    parameter int C_ACE_DATA_WIDTH = 128,
    parameter int C_LINE_BEATS     = 4,
    parameter int C_CNT_WIDTH      = 8
) (
    input  logic                                     ace_aclk,
    input  logic                                     ace_aresetn,
    input  logic                                     i_enable,
    input  logic [C_ACE_DATA_WIDTH*C_LINE_BEATS-1:0] i_pattern,
    input  logic                                     i_data_valid,
    input  logic                                     i_data_ready,
    input  logic [C_ACE_DATA_WIDTH-1:0]              i_data,
    input  logic                                     i_data_last,
    input  logic                                     i_clear,
    output logic                                     o_pattern_match,
    output logic                                     o_protocol_err,
    output logic [C_CNT_WIDTH-1:0]                   o_match_count,
    output logic                                     o_busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SOL = 2'd1,
        COLLECT  = 2'd2,
        FLUSH    = 2'd3
    } state_t;

    localparam logic [1:0] LAST_IDX = 2'(C_LINE_BEATS - 1);

    state_t                  state_q,     state_d;
    logic                    mid_burst_q, mid_burst_d;
    logic [1:0]              idx_q,       idx_d;
    logic                    eq_q,        eq_d;
    logic                    match_q,     match_d;
    logic                    err_q,       err_d;
    logic                    busy_q,      busy_d;
    logic [C_CNT_WIDTH-1:0]  count_q,     count_d;

    logic beat;
    logic slice_eq;

    function automatic logic [C_ACE_DATA_WIDTH-1:0] pattern_slice(
        input logic [C_ACE_DATA_WIDTH*C_LINE_BEATS-1:0] pat,
        input logic [1:0]                               k
    );
        return pat[int'(k)*C_ACE_DATA_WIDTH +: C_ACE_DATA_WIDTH];
    endfunction

    function automatic logic [C_CNT_WIDTH-1:0] sat_inc(input logic [C_CNT_WIDTH-1:0] c);
        return (c == '1) ? c : c + 1'b1;
    endfunction

    always_comb begin
        beat     = i_data_valid & i_data_ready;
        // Pattern is sampled on every beat, never latched.
        slice_eq = (i_data == pattern_slice(i_pattern, idx_q));

        state_d     = state_q;
        mid_burst_d = mid_burst_q;
        idx_d       = idx_q;
        eq_d        = eq_q;
        match_d     = 1'b0;
        err_d       = 1'b0;

        // Burst alignment is tracked regardless of state or enable, so that
        // arming in the middle of a burst can be detected.
        if (beat) begin
            mid_burst_d = ~i_data_last;
        end

        unique case (state_q)
            IDLE: begin
                idx_d = 2'd0;
                eq_d  = 1'b1;
                // Use the post-beat alignment so a beat in this very cycle
                // is accounted for when choosing where to start.
                if (i_enable) begin
                    state_d = mid_burst_d ? WAIT_SOL : COLLECT;
                end
            end
            WAIT_SOL: begin
                if (beat && i_data_last) begin
                    state_d = COLLECT;
                    idx_d   = 2'd0;
                    eq_d    = 1'b1;
                end
            end
            COLLECT: begin
                if (beat) begin
                    if (i_data_last) begin
                        if (idx_q == LAST_IDX) begin
                            match_d = eq_q & slice_eq;
                        end else begin
                            err_d = 1'b1;
                        end
                        idx_d = 2'd0;
                        eq_d  = 1'b1;
                    end else if (idx_q == LAST_IDX) begin
                        // Burst longer than a line: drop the rest of it.
                        err_d   = 1'b1;
                        state_d = FLUSH;
                        idx_d   = 2'd0;
                        eq_d    = 1'b1;
                    end else begin
                        idx_d = idx_q + 2'd1;
                        eq_d  = eq_q & slice_eq;
                    end
                end
            end
            FLUSH: begin
                if (beat && i_data_last) begin
                    state_d = COLLECT;
                    idx_d   = 2'd0;
                    eq_d    = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Disarming wins over everything except a line that completes with a
        // match in the same cycle; partial lines vanish silently.
        if (!i_enable) begin
            state_d = IDLE;
            idx_d   = 2'd0;
            eq_d    = 1'b1;
            err_d   = 1'b0;
        end

        busy_d = (state_d == COLLECT) || (state_d == FLUSH);

        // Clear beats a coincident match pulse.
        if (i_clear) begin
            count_d = '0;
        end else if (match_q) begin
            count_d = sat_inc(count_q);
        end else begin
            count_d = count_q;
        end
    end

    always_ff @(posedge ace_aclk or negedge ace_aresetn) begin
        if (!ace_aresetn) begin
            state_q     <= IDLE;
            mid_burst_q <= 1'b0;
            idx_q       <= 2'd0;
            eq_q        <= 1'b1;
            match_q     <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            mid_burst_q <= mid_burst_d;
            idx_q       <= idx_d;
            eq_q        <= eq_d;
            match_q     <= match_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            count_q     <= count_d;
        end
    end

    assign o_pattern_match = match_q;
    assign o_protocol_err  = err_q;
    assign o_match_count   = count_q;
    assign o_busy          = busy_q;

endmodule

// File: tb/tb_devil_pattern_matcher.sv
// -----------------------------------------------------------------------------
// tb_devil_pattern_matcher
//
// Directed bench for devil_pattern_matcher: drives beats of the tapped channel
// and compares outputs against hand-computed values.
// -----------------------------------------------------------------------------
module tb_devil_pattern_matcher;

    localparam int W = 128;
    localparam int B = 4;
    localparam int CW = 8;

    logic           clk;
    logic           rst_n;
    logic           i_enable;
    logic [W*B-1:0] i_pattern;
    logic           i_data_valid;
    logic           i_data_ready;
    logic [W-1:0]   i_data;
    logic           i_data_last;
    logic           i_clear;
    logic           o_pattern_match;
    logic           o_protocol_err;
    logic [CW-1:0]  o_match_count;
    logic           o_busy;

    int checks;
    int failures;
    int mcnt;
    int ecnt;

    devil_pattern_matcher #(
        .C_ACE_DATA_WIDTH(W),
        .C_LINE_BEATS    (B),
        .C_CNT_WIDTH     (CW)
    ) dut (
        .ace_aclk       (clk),
        .ace_aresetn    (rst_n),
        .i_enable       (i_enable),
        .i_pattern      (i_pattern),
        .i_data_valid   (i_data_valid),
        .i_data_ready   (i_data_ready),
        .i_data         (i_data),
        .i_data_last    (i_data_last),
        .i_clear        (i_clear),
        .o_pattern_match(o_pattern_match),
        .o_protocol_err (o_protocol_err),
        .o_match_count  (o_match_count),
        .o_busy         (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (o_pattern_match) mcnt++;
        if (o_protocol_err)  ecnt++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] sl(input int k);
        return i_pattern[k*W +: W];
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [W-1:0] d, input logic last);
        i_data_valid = 1'b1;
        i_data_ready = 1'b1;
        i_data       = d;
        i_data_last  = last;
        cyc();
        i_data_valid = 1'b0;
        i_data_ready = 1'b0;
        i_data_last  = 1'b0;
    endtask

    task automatic good_line();
        for (int k = 0; k < B; k++) beat(sl(k), k == B - 1);
    endtask

    initial begin
        logic [W-1:0] d;
        int m0;
        int e0;
        checks = 0; failures = 0; mcnt = 0; ecnt = 0;
        rst_n = 1'b0; i_enable = 1'b0; i_data_valid = 1'b0; i_data_ready = 1'b0;
        i_data = '0; i_data_last = 1'b0; i_clear = 1'b0;
        i_pattern = {32'heb624e0d, 32'h11111111, 32'h22222222, 32'h33333333,
                     32'h44444444, 32'h55555555, 32'h66666666, 32'h77777777,
                     32'h88888888, 32'h99999999, 32'haaaaaaaa, 32'hbbbbbbbb,
                     32'hcccccccc, 32'hdddddddd, 32'heeeeeeee, 32'hd54783c2};

        // Reset state
        cyc(); cyc();
        check("rst_match", o_pattern_match, 0);
        check("rst_err", o_protocol_err, 0);
        check("rst_count", o_match_count, 0);
        check("rst_busy", o_busy, 0);
        rst_n = 1'b1;
        i_enable = 1'b1;
        cyc();
        check("arm_busy", o_busy, 1);

        // Basic match: pulse exactly one cycle after the last beat
        check("word0", sl(0)[31:0], 64'hd54783c2);
        good_line();
        check("m1_pulse", o_pattern_match, 1);
        check("m1_err", o_protocol_err, 0);
        cyc();
        check("m1_pulse_end", o_pattern_match, 0);
        check("m1_count", o_match_count, 1);

        // One corrupted word in beat 2
        m0 = mcnt; e0 = ecnt;
        d = sl(2); d[31:0] = 32'h0;
        beat(sl(0), 0); beat(sl(1), 0); beat(d, 0); beat(sl(3), 1);
        cyc(); cyc();
        check("bad_nomatch", mcnt - m0, 0);
        check("bad_noerr", ecnt - e0, 0);
        check("bad_count", o_match_count, 1);

        // Arm in mid-burst: wait for start of line
        i_enable = 1'b0;
        cyc(); cyc();
        check("dis_busy", o_busy, 0);
        beat(sl(0), 0); beat(sl(1), 0);
        i_enable = 1'b1;
        cyc(); cyc();
        check("wsol_busy", o_busy, 0);
        m0 = mcnt; e0 = ecnt;
        beat(sl(2), 0); beat(sl(3), 1);
        check("wsol_nomatch", o_pattern_match, 0);
        check("wsol_busy2", o_busy, 1);
        cyc();
        check("wsol_nopulse", mcnt - m0, 0);
        check("wsol_noerr", ecnt - e0, 0);
        good_line();
        check("wsol_next_match", o_pattern_match, 1);
        cyc();
        check("wsol_count", o_match_count, 2);

        // Short burst
        beat(sl(0), 0); beat(sl(1), 1);
        check("short_err", o_protocol_err, 1);
        check("short_nomatch", o_pattern_match, 0);
        cyc();
        check("short_err_end", o_protocol_err, 0);

        // Long burst (6 beats): error after beat 3, then flush
        m0 = mcnt;
        beat(sl(0), 0); beat(sl(1), 0); beat(sl(2), 0); beat(sl(3), 0);
        check("long_err", o_protocol_err, 1);
        check("long_busy", o_busy, 1);
        beat(sl(0), 0);
        check("flush_err_end", o_protocol_err, 0);
        beat(sl(1), 1);
        cyc();
        check("long_nomatch", mcnt - m0, 0);
        good_line();
        check("after_flush_match", o_pattern_match, 1);
        cyc();
        check("after_flush_count", o_match_count, 3);

        // Saturation: 3 + 256 matches -> 255
        for (int n = 0; n < 256; n++) good_line();
        cyc();
        check("sat_count", o_match_count, 255);
        good_line();
        check("clr_pulse", o_pattern_match, 1);
        check("clr_pre", o_match_count, 255);
        i_clear = 1'b1;
        cyc();
        i_clear = 1'b0;
        check("clr_count", o_match_count, 0);

        // Reset during beat 2 drops the line and the count
        good_line();
        cyc();
        check("pre_rst_count", o_match_count, 1);
        m0 = mcnt;
        beat(sl(0), 0); beat(sl(1), 0);
        i_data_valid = 1'b1; i_data_ready = 1'b1; i_data = sl(2);
        #2 rst_n = 1'b0;
        #1;
        check("mrst_busy", o_busy, 0);
        check("mrst_count", o_match_count, 0);
        @(posedge clk); #1;
        i_data_valid = 1'b0; i_data_ready = 1'b0;
        rst_n = 1'b1;
        cyc(); cyc();
        check("mrst_nopulse", mcnt - m0, 0);
        check("mrst_rearm_busy", o_busy, 1);

        // Final matching beat coincides with enable falling
        beat(sl(0), 0); beat(sl(1), 0); beat(sl(2), 0);
        i_enable = 1'b0;
        beat(sl(3), 1);
        check("fall_match", o_pattern_match, 1);
        cyc();
        check("fall_idle", o_busy, 0);
        check("fall_count", o_match_count, 1);

        // Enable drops during beat 2: no match, no error
        i_enable = 1'b1;
        cyc();
        m0 = mcnt; e0 = ecnt;
        beat(sl(0), 0); beat(sl(1), 0);
        i_enable = 1'b0;
        beat(sl(2), 0); beat(sl(3), 1);
        cyc();
        check("drop_nomatch", mcnt - m0, 0);
        check("drop_noerr", ecnt - e0, 0);
        i_enable = 1'b1;
        cyc();
        good_line();
        check("rearm_match", o_pattern_match, 1);
        cyc();

        // Stalls (valid without ready) between beats are ignored
        for (int k = 0; k < B; k++) begin
            if (k > 0) begin
                i_data_valid = 1'b1; i_data_ready = 1'b0;
                i_data = '0; i_data_last = 1'b1;
                cyc(); cyc();
            end
            beat(sl(k), k == B - 1);
        end
        check("stall_match", o_pattern_match, 1);
        check("stall_noerr", o_protocol_err, 0);
        cyc();
        check("stall_count", o_match_count, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/devil_pattern_matcher.md
DEVIL_PATTERN_MATCHER -- requirements
Module: devil_pattern_matcher

Interface
REQ-001 SHALL have parameter C_ACE_DATA_WIDTH, default 128: width of one monitored data beat.
REQ-002 SHALL have parameter C_LINE_BEATS, default 4: number of beats per cache line; the fixed value is 4.
REQ-003 SHALL have parameter C_CNT_WIDTH, default 8: width of the match counter.
REQ-004 SHALL have port ace_aclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port ace_aresetn, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port i_enable, input, 1 bit: arms matching; the devil controller holds it high in its leak state.
REQ-007 SHALL have port i_pattern, input, C_ACE_DATA_WIDTH*4 bits: target line; bits [128k+127:128k] are compared against beat k.
REQ-008 SHALL have port i_data_valid, input, 1 bit: valid signal of the tapped data channel.
REQ-009 SHALL have port i_data_ready, input, 1 bit: ready signal of the tapped data channel; the block only observes it and never drives it.
REQ-010 SHALL have port i_data, input, C_ACE_DATA_WIDTH bits: beat payload.
REQ-011 SHALL have port i_data_last, input, 1 bit: marks the final beat of a burst.
REQ-012 SHALL have port i_clear, input, 1 bit: synchronous clear of o_match_count.
REQ-013 SHALL have port o_pattern_match, output, 1 bit: one-cycle pulse when a full line equals i_pattern.
REQ-014 SHALL have port o_protocol_err, output, 1 bit: one-cycle pulse when a burst has the wrong length.
REQ-015 SHALL have port o_match_count, output, C_CNT_WIDTH bits: saturating count of matches.
REQ-016 SHALL have port o_busy, output, 1 bit: high while in COLLECT or FLUSH.

Function
REQ-017 SHALL define a beat as a cycle with i_data_valid=1 and i_data_ready=1; all other cycles SHALL be ignored.
REQ-018 SHALL track burst alignment at all times, independent of i_enable: a mid_burst flag set by any non-last beat and cleared by any last beat.
REQ-019 SHALL implement states IDLE, WAIT_SOL, COLLECT and FLUSH.
REQ-020 IDLE: with i_enable=1 and mid_burst=0, SHALL go to COLLECT; with i_enable=1 and mid_burst=1, SHALL go to WAIT_SOL.
REQ-021 WAIT_SOL: SHALL go to COLLECT after the next last beat; a line already in progress SHALL never be matched.
REQ-022 COLLECT: SHALL count beats with a 2-bit index starting at 0.
REQ-023 COLLECT: for beat k, SHALL AND the result of i_data == i_pattern slice k into a registered eq flag, with eq=1 at line start.
REQ-024 COLLECT, beat k=3 with last=1: if eq and the slice-3 compare are both true, o_pattern_match SHALL be 1 in the next cycle only; the index SHALL reset to 0 and the state SHALL remain COLLECT.
REQ-025 COLLECT, last=1 on beat k<3: SHALL pulse o_protocol_err the next cycle, emit no match, reset the index and remain in COLLECT.
REQ-026 COLLECT, beat k=3 with last=0: SHALL pulse o_protocol_err the next cycle, emit no match and go to FLUSH.
REQ-027 FLUSH: SHALL discard beats until a last beat, then go to COLLECT with index 0.
REQ-028 SHALL go to IDLE in the cycle after i_enable falls, from any state; a partial line SHALL be dropped with no match and no error.
REQ-029 A final matching beat that coincides with i_enable falling SHALL still produce the match pulse.
REQ-030 i_pattern SHALL be sampled per beat, not latched; changing it mid-line affects only later beats.
REQ-031 o_match_count SHALL increment on each o_pattern_match pulse and saturate at all-ones.
REQ-032 When i_clear and a match pulse occur in the same cycle, i_clear SHALL take priority and the count SHALL become 0.
REQ-033 All outputs SHALL be registered; match latency SHALL be 1 cycle after the final beat.

Reset
REQ-034 Asserting ace_aresetn=0 SHALL immediately force: state IDLE, mid_burst 0, index 0, eq 1, o_pattern_match 0, o_protocol_err 0, o_match_count 0, o_busy 0.
REQ-035 Reset SHALL be released synchronously to ace_aclk; a reset in mid-line SHALL drop that line with no pulse.

Verification
REQ-036 Enable=1; send 4 beats equal to the pattern slices (beat0 word0 = 32'hd54783c2, beat3 word3 = 32'heb624e0d), last on beat 3 -> o_pattern_match=1 for exactly 1 cycle, 1 cycle after beat 3; count=1.
REQ-037 Same line but beat2 word0 changed to 32'h00000000 -> no match, no error, count unchanged.
REQ-038 Raise enable after beat 1 of a matching burst -> state is WAIT_SOL, no match; the next matching burst -> match.
REQ-039 Send a burst with last on beat 1 -> o_protocol_err pulse; send a 6-beat burst -> error after beat 3, then FLUSH, no match; the following good line -> match.
REQ-040 Send 256 matching lines with C_CNT_WIDTH=8 -> count stays 255; i_clear in the same cycle as a match -> count 0.
REQ-041 Assert reset during beat 2, or drop enable during beat 2 -> no pulse; with valid=1 and ready=0 stalls between beats -> the match still occurs.
